// File: rtl/hist_stream_tx.sv
// Luma stream transmitter for the histogram-equalisation stage: counter-driven
// timing, valid/ready pixel pull, underflow and SOF checks. Optional TPG: HIST_TX_TPG_EN.
module hist_stream_tx #(
    parameter int         H_DISP     = 480,
    parameter int         V_DISP     = 272,
    parameter int         H_BLANK    = 40,
    parameter int         V_BLANK    = 8,
    parameter logic [7:0] FILL_VALUE = 8'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  pix_data,
    input  logic        pix_sof,
    input  logic        pix_valid,
`ifdef HIST_TX_TPG_EN
    input  logic        tpg_sel,
`endif
    output logic        pix_ready,
    output logic        Y_vsync,
    output logic        Y_hsync,
    output logic        Y_de,
    output logic [7:0]  Y_data,
    output logic        busy,
    output logic        underflow,
    output logic        sof_err,
    output logic [15:0] underflow_cnt
);

    localparam int H_TOTAL = H_DISP + H_BLANK;
    localparam int V_TOTAL = V_DISP + V_BLANK;
    // At least 8 bits so the test pattern can always take h_cnt[7:0] ^ v_cnt[7:0]
    localparam int HW_R = $clog2(H_TOTAL);
    localparam int VW_R = $clog2(V_TOTAL);
    localparam int HW   = (HW_R < 8) ? 8 : HW_R;
    localparam int VW   = (VW_R < 8) ? 8 : VW_R;

    localparam logic [HW-1:0] H_ACT  = HW'(H_DISP);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_DISP);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    // The downstream 256-entry table rebuild needs this much vertical gap
    generate
        if (V_BLANK * (H_DISP + H_BLANK) < 262) begin : g_gap_chk
            $error("hist_stream_tx: V_BLANK*(H_DISP+H_BLANK) must be >= 262");
        end
    endgenerate

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t         r_state;
    logic [HW-1:0]  r_h_cnt;
    logic [VW-1:0]  r_v_cnt;

    logic w_run, w_active, w_first, w_h_last, w_v_last, w_frame_end;
    logic w_tpg, w_ready, w_xfer, w_miss;

    assign w_run       = (r_state == S_RUN);
    assign w_active    = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_first     = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_h_last    = (r_h_cnt == H_LAST);
    assign w_v_last    = (r_v_cnt == V_LAST);
    assign w_frame_end = w_h_last && w_v_last;

`ifdef HIST_TX_TPG_EN
    logic r_tpg;
    // Pattern select latched only where the next frame begins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_tpg <= 1'b0;
        else if (en && ((r_state == S_IDLE) || w_frame_end))
            r_tpg <= tpg_sel;
    end
    assign w_tpg = r_tpg;
`else
    assign w_tpg = 1'b0;
`endif

    assign w_ready   = w_run && w_active && !w_tpg;
    assign w_xfer    = w_ready && pix_valid;
    assign w_miss    = w_ready && !pix_valid;
    assign pix_ready = w_ready;
    assign busy      = w_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_h_cnt <= '0;
                    r_v_cnt <= '0;
                    if (en) r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_h_last) begin
                        r_h_cnt <= '0;
                        if (w_v_last) begin
                            r_v_cnt <= '0;
                            // en only matters here: a dropped en still finishes the frame
                            if (!en) r_state <= S_IDLE;
                        end else begin
                            r_v_cnt <= r_v_cnt + 1'b1;
                        end
                    end else begin
                        r_h_cnt <= r_h_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y_vsync       <= 1'b0;
            Y_hsync       <= 1'b0;
            Y_de          <= 1'b0;
            Y_data        <= 8'd0;
            sof_err       <= 1'b0;
            underflow     <= 1'b0;
            underflow_cnt <= 16'd0;
        end else begin
            Y_vsync <= w_run && (r_v_cnt < V_ACT);
            Y_hsync <= w_run && w_active;
            Y_de    <= w_run && w_active;

            if (w_xfer)
                Y_data <= pix_data;
            else if (w_run && w_active)
                Y_data <= w_tpg ? (r_h_cnt[7:0] ^ r_v_cnt[7:0]) : FILL_VALUE;
            else
                Y_data <= 8'd0;

            sof_err <= w_xfer && (pix_sof != w_first);

            // First active pixel restarts the count, itself counted if missing
            if (w_run && w_first)
                underflow_cnt <= w_miss ? 16'd1 : 16'd0;
            else if (w_miss && (underflow_cnt != 16'hFFFF))
                underflow_cnt <= underflow_cnt + 16'd1;

            if (w_run && (r_h_cnt == '0) && (r_v_cnt == V_ACT))
                underflow <= (underflow_cnt != 16'd0);
        end
    end

endmodule

// File: tb/tb_hist_stream_tx.sv
// Bench for hist_stream_tx: per-cycle reference model feeds a scoreboard queue,
// plus frame-level checks on sequence, gap length, underflow and SOF pulses.
module tb_hist_stream_tx;

    localparam int         HD   = 8;
    localparam int         VD   = 4;
    localparam int         HB   = 4;
    localparam int         VB   = 70;
    localparam int         HT   = HD + HB;
    localparam int         VT   = VD + VB;
    localparam logic [7:0] FILL = 8'd0;

    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0;
    logic [7:0]  pix_data = 8'd0;
    logic        pix_sof = 1'b0, pix_valid = 1'b0;
    logic        pix_ready, Y_vsync, Y_hsync, Y_de, busy, underflow, sof_err;
    logic [7:0]  Y_data;
    logic [15:0] underflow_cnt;

    always #5 clk = ~clk;

    hist_stream_tx #(.H_DISP(HD), .V_DISP(VD), .H_BLANK(HB), .V_BLANK(VB), .FILL_VALUE(FILL)) dut (
`ifdef HIST_TX_TPG_EN
        .tpg_sel      (1'b0),
`endif
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .pix_data     (pix_data),
        .pix_sof      (pix_sof),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .Y_vsync      (Y_vsync),
        .Y_hsync      (Y_hsync),
        .Y_de         (Y_de),
        .Y_data       (Y_data),
        .busy         (busy),
        .underflow    (underflow),
        .sof_err      (sof_err),
        .underflow_cnt(underflow_cnt)
    );

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic       vs;
        logic       hs;
        logic       de;
        logic [7:0] d;
        logic       se;
    } exp_t;

    exp_t q[$];

    // Reference model state, advanced once per clock by step()
    logic        m_run = 1'b0, m_uf = 1'b0;
    int          m_h = 0, m_v = 0, pcount = 0;
    logic [15:0] m_cnt = 16'd0;
    int          sof_h = 0;
    logic        drop_on = 1'b0;

    task automatic model_reset();
        m_run = 1'b0; m_h = 0; m_v = 0; m_cnt = 16'd0; m_uf = 1'b0;
        q.delete();
    endtask

    task automatic step();
        exp_t e;
        logic act;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            act  = m_run && (m_h < HD) && (m_v < VD);
            e.vs = m_run && (m_v < VD);
            e.hs = act;
            e.de = act;
            e.d  = !act ? 8'd0 : (pix_valid ? pix_data : FILL);
            e.se = act && pix_valid && (pix_sof != ((m_h == 0) && (m_v == 0)));
            q.push_back(e);
            if (m_run && (m_h == 0) && (m_v == VD)) m_uf = (m_cnt != 16'd0);
            if (m_run && (m_h == 0) && (m_v == 0))
                m_cnt = (act && !pix_valid) ? 16'd1 : 16'd0;
            else if (act && !pix_valid && (m_cnt != 16'hFFFF))
                m_cnt = m_cnt + 16'd1;
            if (act && pix_valid) pcount++;
            if (!m_run) begin
                if (en) begin m_run = 1'b1; m_h = 0; m_v = 0; end
            end else if (m_h == HT - 1) begin
                m_h = 0;
                if (m_v == VT - 1) begin
                    m_v = 0;
                    if (!en) m_run = 1'b0;
                end else begin
                    m_v++;
                end
            end else begin
                m_h++;
            end
        end
        #1;
        pix_data  = 8'(pcount);
        pix_sof   = m_run && (m_v == 0) && (m_h == sof_h);
        pix_valid = !(drop_on && (m_v == 1) && (m_h >= 2) && (m_h <= 4));
    endtask

    task automatic wait_pos(input int h, input int v);
        bit hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            step();
            hit = m_run && (m_h == h) && (m_v == v);
        end
        if (!hit) chk("wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_end();
        wait_pos(HT - 1, VT - 1);
    endtask

    // Output monitor: scoreboard pop plus frame statistics
    int   de_cnt = 0, sof_cnt = 0, fill_cnt = 0, seq_idx = 0, gap = 0, last_gap = 0;
    logic seq_on = 1'b0, prev_vs = 1'b0, in_gap = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_out", {Y_vsync, Y_hsync, Y_de, Y_data, sof_err, underflow, busy, pix_ready, underflow_cnt}, 32'd0);
            end else begin
                e = (q.size() > 0) ? q.pop_front() : '0;
                chk("vsync", Y_vsync, e.vs);
                chk("hsync", Y_hsync, e.hs);
                chk("de", Y_de, e.de);
                chk("data", Y_data, e.d);
                chk("sof_err", sof_err, e.se);
                chk("ready", pix_ready, m_run && (m_h < HD) && (m_v < VD));
                chk("busy", busy, m_run);
                chk("ucnt", underflow_cnt, m_cnt);
                chk("uflag", underflow, m_uf);
                if (Y_de) de_cnt++;
                if (sof_err) sof_cnt++;
                if (Y_de && (Y_data == FILL)) fill_cnt++;
                if (seq_on && Y_de) begin
                    chk("seq", Y_data, seq_idx);
                    seq_idx++;
                end
                if (Y_vsync) begin
                    if (in_gap) begin last_gap = gap; in_gap = 1'b0; end
                end else begin
                    if (prev_vs) begin in_gap = 1'b1; gap = 0; end
                    if (in_gap) gap++;
                end
                prev_vs = Y_vsync;
            end
        end
    end

    int de_b, fill_b, sof_b;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", pix_ready, 1'b0);
        chk("rst_ucnt", underflow_cnt, 16'd0);

        // Frame 1: clean stream 0..31
        rst_n = 1'b1; en = 1'b1; seq_on = 1'b1;
        wait_end();
        seq_on = 1'b0;
        chk("f1_seq_len", seq_idx, 32);
        chk("f1_de", de_cnt, 32);
        chk("f1_sof", sof_cnt, 0);
        chk("f1_uf", underflow, 1'b0);
        fill_b = fill_cnt; drop_on = 1'b1;

        // Frame 2: three missing pixels on line 2
        wait_end();
        chk("f2_ucnt", underflow_cnt, 16'd3);
        chk("f2_uf", underflow, 1'b1);
        chk("f2_fill", fill_cnt - fill_b, 3);
        chk("vgap", last_gap, VB * HT);
        drop_on = 1'b0; sof_h = 5; sof_b = sof_cnt;

        // Frame 3: SOF on pixel 5 instead of 0
        wait_end();
        chk("f3_sof", sof_cnt - sof_b, 2);
        chk("f3_uf", underflow, 1'b0);
        chk("f3_ucnt", underflow_cnt, 16'd0);
        sof_h = 0; de_b = de_cnt;

        // Frame 4: en dropped during line 1, frame still completes
        wait_pos(3, 1);
        en = 1'b0;
        wait_end();
        step();
        chk("idle_busy", busy, 1'b0);
        chk("idle_ready", pix_ready, 1'b0);
        repeat (30) step();
        chk("f4_de", de_cnt - de_b, 32);
        chk("idle_hold", busy, 1'b0);

        // Frame 5: async reset mid-line, then a fresh frame
        en = 1'b1;
        wait_pos(4, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {Y_vsync, Y_hsync, Y_de, Y_data, sof_err, underflow, busy, pix_ready}, 32'd0);
        chk("async_ucnt", underflow_cnt, 16'd0);
        model_reset();
        step();
        rst_n = 1'b1;
        de_b = de_cnt;
        step();
        chk("fresh_ready", pix_ready, 1'b1);
        chk("fresh_busy", busy, 1'b1);
        wait_end();
        chk("fresh_de", de_cnt - de_b, 32);

        en = 1'b0;
        repeat (6) step();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
